// File: rtl/icetap_jtag_tap.sv
// icetap TAP controller: TMS state machine, IR, BYPASS and optional IDCODE DR.
// Define ICETAP_IDCODE_EN to build in the 32-bit IDCODE register.
module icetap_jtag_tap #(
    parameter int                    IR_LENGTH    = 4,
    parameter logic [IR_LENGTH-1:0]  IR_EXTEST    = IR_LENGTH'(4'h0),
    parameter logic [IR_LENGTH-1:0]  IR_SCAN_N    = IR_LENGTH'(4'h2),
    parameter logic [IR_LENGTH-1:0]  IR_IDCODE    = IR_LENGTH'(4'he),
    parameter logic [IR_LENGTH-1:0]  IR_BYPASS    = IR_LENGTH'(4'hf),
    parameter logic [31:0]           IDCODE_VALUE = 32'h1000_0001
) (
    input  logic tck,
    input  logic reset_,
    input  logic tms,
    input  logic tdi,
    input  logic icetap_tdo,
    output logic tdo,
    output logic tdo_oe,
    output logic test_logic_reset,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic scan_n_ir,
    output logic extest_ir
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } state_t;

`ifdef ICETAP_IDCODE_EN
    localparam logic [IR_LENGTH-1:0] IR_RESET = IR_IDCODE;
`else
    localparam logic [IR_LENGTH-1:0] IR_RESET = IR_BYPASS;
`endif

    state_t               state;
    state_t               state_nxt;
    logic [IR_LENGTH-1:0] ir;
    logic [IR_LENGTH-1:0] ir_sr;
    logic                 bypass;
    logic                 sel_idcode;
    logic                 idcode_bit;

    always_ff @(posedge tck) begin
        if (!reset_) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            TLR:      state_nxt = tms ? TLR      : RTI;
            RTI:      state_nxt = tms ? SEL_DR   : RTI;
            SEL_DR:   state_nxt = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_nxt = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_nxt = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_nxt = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_nxt = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_nxt = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_nxt = tms ? SEL_DR   : RTI;
            SEL_IR:   state_nxt = tms ? TLR      : CAP_IR;
            CAP_IR:   state_nxt = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_nxt = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_nxt = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_nxt = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_nxt = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_nxt = tms ? SEL_DR   : RTI;
            default:  state_nxt = TLR;
        endcase
    end

    always_ff @(posedge tck) begin
        if (!reset_) begin
            ir    <= IR_RESET;
            ir_sr <= '0;
        end else begin
            unique case (state)
                TLR:      ir    <= IR_RESET;
                CAP_IR:   ir_sr <= IR_LENGTH'(1);
                SHIFT_IR: ir_sr <= {tdi, ir_sr[IR_LENGTH-1:1]};
                UPD_IR:   ir    <= ir_sr;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge tck) begin
        if (!reset_) begin
            bypass <= 1'b0;
        end else if (state == CAP_DR) begin
            bypass <= 1'b0;
        end else if (state == SHIFT_DR) begin
            bypass <= tdi;
        end
    end

`ifdef ICETAP_IDCODE_EN
    logic [31:0] idcode_sr;

    assign sel_idcode = (ir == IR_IDCODE);
    assign idcode_bit = idcode_sr[0];

    always_ff @(posedge tck) begin
        if (!reset_) begin
            idcode_sr <= '0;
        end else if (sel_idcode && state == CAP_DR) begin
            idcode_sr <= IDCODE_VALUE;
        end else if (sel_idcode && state == SHIFT_DR) begin
            idcode_sr <= {tdi, idcode_sr[31:1]};
        end
    end
`else
    // IDCODE opcode falls through to bypass in this build
    logic unused_idcode;

    assign unused_idcode = ^{IR_IDCODE, IDCODE_VALUE};
    assign sel_idcode    = 1'b0;
    assign idcode_bit    = 1'b0;
`endif

    assign test_logic_reset = (state == TLR);
    assign capture_dr       = (state == CAP_DR);
    assign shift_dr         = (state == SHIFT_DR);
    assign update_dr        = (state == UPD_DR);
    assign tdo_oe           = (state == SHIFT_DR) || (state == SHIFT_IR);
    assign scan_n_ir        = (ir == IR_SCAN_N);
    assign extest_ir        = (ir == IR_EXTEST);

    always_comb begin
        tdo = 1'b0;
        if (state == SHIFT_IR) begin
            tdo = ir_sr[0];
        end else if (state == SHIFT_DR) begin
            if (scan_n_ir || extest_ir) begin
                tdo = icetap_tdo;
            end else if (sel_idcode) begin
                tdo = idcode_bit;
            end else begin
                tdo = bypass;
            end
        end
    end

endmodule
